// File: rtl/seg_scan_capture_if.sv
// Multiplexed 7-segment scan bus, as driven by the display driver.
// seg_sel is active-low one-hot; seg_led is active-low segments.
interface seg_scan_capture_if;

  logic [5:0] seg_sel;
  logic [7:0] seg_led;

  modport master (
    output seg_sel,
    output seg_led
  );

  modport slave (
    input seg_sel,
    input seg_led
  );

endinterface

// File: rtl/seg_scan_capture.sv
// Receive side of the 6-digit scan bus: settles, samples and decodes
// each digit, assembles in-order sweeps and converts frames to binary.
module seg_scan_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_capture_if.slave bus,
  output logic [23:0]       bcd_data,
  output logic [5:0]        point,
  output logic              sign,
  output logic [19:0]       data,
  output logic              pattern_err,
  output logic              frame_valid,
  output logic              disp_off
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // set_q holds (cycles stable - 1); the sample fires on the
  // SETTLE_CYC-th edge that sees the same legal select.
  localparam logic [SW-1:0] SET_HIT = SW'(SETTLE_CYC - 2);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

  localparam logic [3:0] C_BLANK = 4'd10;
  localparam logic [3:0] C_MINUS = 4'd11;
  localparam logic [3:0] C_ILL   = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [5:0]    sel_q;
  logic [SW-1:0] set_q;
  logic          legal;
  logic [2:0]    idx;
  logic          stable;
  logic          samp;

  logic [3:0]    code;
  logic          dot;

  logic [TW-1:0] to_q;
  logic          to_hit;

  logic [5:0][3:0] dig_q;
  logic [5:0]      dot_q;
  logic [2:0]      exp_q;
  logic            act_q;
  logic            take0;
  logic            takek;
  logic            complete;

  logic [5:0][3:0] frm_dig;
  logic [5:0]      frm_dot;

  logic [5:0][3:0] sh_dig;
  logic [5:0]      sh_dot;
  logic            sh_sign;
  logic            sh_err;
  logic [19:0]     acc_q;
  logic [19:0]     acc_x10;
  logic [19:0]     dval;
  logic [2:0]      cidx_q;

  // Map the active-low one-hot select to a digit index.
  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    unique case (bus.seg_sel)
      6'b111110: idx = 3'd0;
      6'b111101: idx = 3'd1;
      6'b111011: idx = 3'd2;
      6'b110111: idx = 3'd3;
      6'b101111: idx = 3'd4;
      6'b011111: idx = 3'd5;
      default:   legal = 1'b0;
    endcase
  end

  assign stable = legal && (bus.seg_sel == sel_q);
  assign samp   = stable && (set_q == SET_HIT);

  // Track the previous select and how long it has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '1;
      set_q <= '0;
    end else begin
      sel_q <= bus.seg_sel;
      if (!stable)
        set_q <= '0;
      else if (set_q != SET_MAX)
        set_q <= set_q + 1'b1;
    end
  end

  // Segment pattern back to digit code; dot is independent.
  always_comb begin
    dot = ~bus.seg_led[7];
    unique case (bus.seg_led[6:0])
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1111000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0010000: code = 4'd9;
      7'b1111111: code = C_BLANK;
      7'b0111111: code = C_MINUS;
      default:    code = C_ILL;
    endcase
  end

  assign to_hit = !samp && (to_q == TO_LAST);

  // Idle-bus watchdog; saturates and flags the display as off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q     <= '0;
      disp_off <= 1'b0;
    end else if (samp) begin
      to_q     <= '0;
      disp_off <= 1'b0;
    end else begin
      if (to_q != TO_MAX)
        to_q <= to_q + 1'b1;
      if (to_hit)
        disp_off <= 1'b1;
    end
  end

  assign take0 = samp && (idx == 3'd0);
  assign takek = samp && act_q && (idx != 3'd0) && (idx == exp_q);
  assign complete = takek && (idx == 3'd5);

  // Sweep assembly: digits must arrive 0..5 in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      dot_q <= '0;
      exp_q <= '0;
      act_q <= 1'b0;
    end else if (take0) begin
      dig_q <= {20'd0, code};
      dot_q <= {5'd0, dot};
      exp_q <= 3'd1;
      act_q <= 1'b1;
    end else if (takek) begin
      dig_q[idx] <= code;
      dot_q[idx] <= dot;
      exp_q      <= exp_q + 1'b1;
      if (idx == 3'd5)
        act_q <= 1'b0;
    end else if (samp || to_hit) begin
      act_q <= 1'b0;
    end
  end

  // The completing digit is merged straight into the shadow copy.
  always_comb begin
    frm_dig    = dig_q;
    frm_dot    = dot_q;
    frm_dig[5] = code;
    frm_dot[5] = dot;
  end

  // Frame flags from the latched codes.
  always_comb begin
    sh_sign = 1'b0;
    sh_err  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sh_dig[i] == C_MINUS)
        sh_sign = 1'b1;
      if (sh_dig[i] == C_ILL)
        sh_err = 1'b1;
    end
  end

  // Non-decimal codes contribute zero to the binary value.
  always_comb begin
    dval = 20'd0;
    if (sh_dig[cidx_q] <= 4'd9)
      dval = {16'd0, sh_dig[cidx_q]};
  end

  assign acc_x10 = {acc_q[16:0], 3'b000} + {acc_q[18:0], 1'b0};

  // Conversion state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: one conversion per frame, extra frames are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (complete) state_d = CONV;
      CONV: if (cidx_q == 3'd0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow latch and most-significant-first multiply-accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dig <= '0;
      sh_dot <= '0;
      acc_q  <= '0;
      cidx_q <= '0;
    end else if (state_q == IDLE) begin
      if (complete) begin
        sh_dig <= frm_dig;
        sh_dot <= frm_dot;
        acc_q  <= '0;
        cidx_q <= 3'd5;
      end
    end else if (state_q == CONV) begin
      acc_q  <= acc_x10 + dval;
      cidx_q <= cidx_q - 1'b1;
    end
  end

  // Publish the frame and pulse frame_valid from DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_data    <= '0;
      point       <= '0;
      sign        <= 1'b0;
      data        <= '0;
      pattern_err <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (state_q == DONE) begin
        bcd_data    <= sh_dig;
        point       <= sh_dot;
        sign        <= sh_sign;
        data        <= acc_q;
        pattern_err <= sh_err;
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised scan-bus stimulus checked against a digit-level
// reference model of sweep assembly and frame conversion.
module tb_seg_scan_capture;

  localparam int S  = 4;
  localparam int TO = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] bcd_data;
  logic [5:0]  point;
  logic        sign;
  logic [19:0] data;
  logic        pattern_err;
  logic        frame_valid;
  logic        disp_off;

  seg_scan_capture_if bus ();

  seg_scan_capture #(
    .SETTLE_CYC (S),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .bcd_data   (bcd_data),
    .point      (point),
    .sign       (sign),
    .data       (data),
    .pattern_err(pattern_err),
    .frame_valid(frame_valid),
    .disp_off   (disp_off)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_fv = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [6:0] pats [12] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h3F
  };

  typedef struct {
    int          cyc;
    logic [23:0] bcd;
    logic [19:0] val;
    logic [5:0]  pt;
    logic        sg;
    logic        er;
  } frame_t;

  frame_t q[$];
  frame_t mf;

  int   m_exp = -1;
  int   m_code [6];
  logic m_dot [6];
  int   m_busy = -100;
  int   last_idx = -1;

  int         w_code [6];
  logic [7:0] w_led [6];

  function automatic int dec(logic [6:0] p);
    for (int i = 0; i < 12; i++)
      if (pats[i] == p) return i;
    return 15;
  endfunction

  function automatic logic [7:0] mk(int c, bit d);
    logic [6:0] p;
    if (c <= 11) return {~d, pats[c]};
    for (int i = 0; i < 100; i++) begin
      p = 7'($urandom);
      if (dec(p) == 15) return {~d, p};
    end
    return {~d, 7'h55};
  endfunction

  function automatic logic [5:0] sel_of(int i);
    logic [5:0] s;
    s = '1;
    if (i >= 0) s[i] = 1'b0;
    return s;
  endfunction

  task automatic m_reset();
    q.delete();
    m_exp = -1;
    m_busy = -100;
  endtask

  task automatic m_sample(int i, logic [7:0] led, int ts);
    frame_t f;
    int pw;
    int v;
    if (i == 0 || (m_exp == i)) begin
      m_code[i] = dec(led[6:0]);
      m_dot[i] = ~led[7];
      m_exp = i + 1;
      if (i == 5) begin
        m_exp = -1;
        if (ts >= m_busy) begin
          f.cyc = ts + 7;
          f.bcd = '0;
          f.pt = '0;
          f.sg = 1'b0;
          f.er = 1'b0;
          v = 0;
          pw = 1;
          for (int k = 0; k < 6; k++) begin
            f.bcd |= 24'(m_code[k]) << (4 * k);
            if (m_code[k] <= 9) v += m_code[k] * pw;
            pw *= 10;
            f.pt[k] = m_dot[k];
            if (m_code[k] == 11) f.sg = 1'b1;
            if (m_code[k] == 15) f.er = 1'b1;
          end
          f.val = 20'(v);
          q.push_back(f);
          m_busy = ts + 8;
        end
      end
    end else begin
      m_exp = -1;
    end
  endtask

  task automatic scan(int i, logic [7:0] led, int hold);
    if (i >= 0 && i == last_idx) begin
      bus.seg_sel = '1;
      @(negedge clk);
    end
    bus.seg_sel = sel_of(i);
    bus.seg_led = led;
    last_idx = i;
    if (i >= 0 && hold >= S) m_sample(i, led, cyc + S);
    repeat (hold) @(negedge clk);
  endtask

  task automatic sweep(int lo, int hi);
    for (int k = 0; k < 6; k++)
      scan(k, w_led[k], $urandom_range(hi, lo));
  endtask

  task automatic set_codes();
    for (int k = 0; k < 6; k++) w_led[k] = mk(w_code[k], 1'b0);
  endtask

  task automatic drain();
    repeat (20) @(negedge clk);
    chk("pending_frames", q.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_bcd"}, bcd_data, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_point"}, point, 0);
    chk({tag, "_sign"}, sign, 0);
    chk({tag, "_err"}, pattern_err, 0);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_off"}, disp_off, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      n_fv++;
      if (q.size() == 0) begin
        chk("fv_unexpected", 1, 0);
      end else begin
        mf = q.pop_front();
        chk("fv_cycle", cyc, mf.cyc);
        chk("bcd_data", bcd_data, mf.bcd);
        chk("data", data, mf.val);
        chk("point", point, mf.pt);
        chk("sign", sign, mf.sg);
        chk("pattern_err", pattern_err, mf.er);
      end
    end
  end

  initial begin
    int n0;
    int gk;
    bit gl;
    int i;
    int h;
    bus.seg_sel = '1;
    bus.seg_led = '1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    w_code = '{6, 5, 4, 3, 2, 1};
    set_codes();
    w_led[2] = mk(4, 1'b1);
    sweep(1000, 1000);
    drain();
    chk("t1_bcd", bcd_data, 24'h123456);
    chk("t1_data", data, 123456);
    chk("t1_point", point, 6'b000100);
    chk("t1_sign", sign, 0);
    chk("t1_err", pattern_err, 0);

    w_code = '{2, 4, 11, 10, 10, 10};
    set_codes();
    sweep(10, 30);
    drain();
    chk("t2_bcd", bcd_data, 24'hAAAB42);
    chk("t2_sign", sign, 1);
    chk("t2_data", data, 42);

    w_code = '{7, 0, 0, 9, 3, 8};
    set_codes();
    w_led[2] = {1'b1, 7'b1010101};
    sweep(6, 12);
    drain();
    chk("t3_err", pattern_err, 1);
    chk("t3_digit2", bcd_data[11:8], 4'hF);
    chk("t3_data", data, 839007);

    for (int k = 0; k < 3; k++) scan(k, w_led[k], 10);
    m_exp = -1;
    scan(-1, 8'hFF, TO + 20);
    chk("t4_off", disp_off, 1);
    n0 = n_fv;
    bus.seg_sel = sel_of(3);
    bus.seg_led = w_led[3];
    last_idx = 3;
    m_sample(3, w_led[3], cyc + S);
    repeat (S - 1) @(negedge clk);
    chk("t4_off_hold", disp_off, 1);
    @(negedge clk);
    chk("t4_off_clear", disp_off, 0);
    repeat (10 - S) @(negedge clk);
    scan(4, w_led[4], 10);
    scan(5, w_led[5], 30);
    chk("t4_no_frame", n_fv - n0, 0);
    sweep(6, 12);
    drain();
    chk("t4_one_frame", n_fv - n0, 1);

    n0 = n_fv;
    w_code = '{1, 1, 2, 2, 3, 3};
    set_codes();
    scan(0, w_led[0], 8);
    scan(1, w_led[1], S - 1);
    for (int k = 2; k < 6; k++) scan(k, w_led[k], 8);
    scan(0, w_led[0], 8);
    scan(1, w_led[1], 8);
    scan(3, w_led[3], 8);
    scan(4, w_led[4], 8);
    scan(5, w_led[5], 20);
    chk("t5_no_frame", n_fv - n0, 0);
    sweep(S, S + 6);
    drain();
    chk("t5_one_frame", n_fv - n0, 1);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 6; k++) begin
        w_code[k] = ($urandom_range(9) == 0) ? 15 : $urandom_range(11);
        w_led[k] = mk(w_code[k], 1'($urandom));
      end
      gl = ($urandom_range(3) == 0);
      gk = $urandom_range(5);
      for (int k = 0; k < 6; k++) begin
        i = k;
        h = $urandom_range(S + 12, S);
        if (gl && k == gk) begin
          if ($urandom_range(1) == 1) h = S - 1;
          else i = $urandom_range(5);
        end
        scan(i, w_led[k], h);
      end
    end
    drain();

    w_code = '{9, 8, 7, 6, 5, 4};
    set_codes();
    for (int k = 0; k < 5; k++) scan(k, w_led[k], 12);
    bus.seg_sel = sel_of(5);
    bus.seg_led = w_led[5];
    last_idx = 5;
    m_sample(5, w_led[5], cyc + S);
    repeat (S + 3) @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_zero("t6_reset");
    repeat (5) @(negedge clk);
    bus.seg_sel = '1;
    last_idx = -1;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_fv;
    for (int k = 3; k < 6; k++) scan(k, w_led[k], 12);
    sweep(8, 20);
    drain();
    chk("t6_one_frame", n_fv - n0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
